// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word block copy bus initiator for the RV32I memory port.
// Optional FILL_EN macro adds fill/fill_value ports for pattern fill instead of copy.
module mem_copy_engine #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
`ifdef FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_value,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_write,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_write_address,
  output logic [31:0]      mem_write_data,
  output logic [31:0]      mem_read_address,
  input  logic [31:0]      mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, XFER, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        src_ptr, dst_ptr;
  logic [LEN_W-1:0]   count;
  logic               misaligned;
  logic               fill_start;
  logic               fill_mode;

  assign misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);

`ifdef FILL_EN
  logic [31:0] fill_value_q;
  logic        fill_q;
  assign fill_start = fill;
  assign fill_mode  = fill_q;
  assign mem_write_data = fill_q ? fill_value_q : mem_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q       <= 1'b0;
      fill_value_q <= 32'h0;
    end else if (state == IDLE && start) begin
      fill_q       <= fill;
      fill_value_q <= fill_value;
    end
  end
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign mem_write_data = mem_read_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned || len_words == '0) state_next = DONE;
          else if (fill_start)              state_next = XFER;
          else                              state_next = READ;
        end
      end
      READ:    state_next = XFER;
      XFER:    if (count == LEN_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read address always tracks src_ptr, so the read issued in XFER fetches the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr <= 32'h0;
      dst_ptr <= 32'h0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= len_words;
            err     <= misaligned;
          end
        end
        READ: src_ptr <= src_ptr + 32'd4;
        XFER: begin
          if (!fill_mode) src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          count   <= count - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign mem_write         = (state == XFER);
  assign mem_funct3        = 3'b010;
  assign mem_write_address = dst_ptr;
  assign mem_read_address  = src_ptr;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - table-driven bench for mem_copy_engine with a behavioural memory.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [11:0] len_words;
`ifdef FILL_EN
  logic        fill;
  logic [31:0] fill_value;
`endif
  logic        busy, done, err, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [0:2047];
  logic [31:0] refm [0:2047];

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
`ifdef FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .busy(busy), .done(done), .err(err), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data)
  );

  // Synchronous-read memory; out-of-range reads return zero, writes are dropped.
  always @(posedge clk) begin
    mem_read_data <= (mem_read_address < 32'h2000) ? mem[mem_read_address[12:2]] : 32'h0;
    if (mem_write && mem_write_address < 32'h2000)
      mem[mem_write_address[12:2]] = mem_write_data;
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [11:0] len;
    logic        fill;
    logic [31:0] fval;
    int          exp_done;
    int          exp_writes;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] seed);
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = {seed, 16'(i)};
      refm[i] = {seed, 16'(i)};
    end
  endtask

  task automatic ref_copy(input vec_t v, input int words);
    logic [31:0] s, d, val;
    for (int i = 0; i < words; i++) begin
      s = v.src + 32'(4 * i);
      d = v.dst + 32'(4 * i);
      if (v.fill) val = v.fval;
      else        val = (s < 32'h2000) ? refm[s[12:2]] : 32'h0;
      if (d < 32'h2000) refm[d[12:2]] = val;
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== refm[i]) n++;
    return n;
  endfunction

  task automatic apply_start(input vec_t v);
    @(negedge clk);
    src_addr  = v.src;
    dst_addr  = v.dst;
    len_words = v.len;
`ifdef FILL_EN
    fill       = v.fill;
    fill_value = v.fval;
`endif
    start = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_cyc, ndone, writes, busy_bad, f3_bad;
    string tag;
    preload(16'(idx + 16'h1100));
    if (!v.exp_err) ref_copy(v, int'(v.len));
    apply_start(v);
    done_cyc = -1; ndone = 0; writes = 0; busy_bad = 0; f3_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_write) writes++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (c <= v.exp_done)) busy_bad++;
      if (mem_funct3 !== 3'b010) f3_bad++;
      if (c == 1) begin
        start    = 1'b0;
        src_addr = 32'h0000_0800;
        dst_addr = 32'h0000_0900;
        len_words = 12'd7;
      end
    end
    tag = $sformatf("v%0d", idx);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_writes"}, 32'(writes), 32'(v.exp_writes));
    chk({tag, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
    chk({tag, "_busy_profile"}, 32'(busy_bad), 32'd0);
    chk({tag, "_funct3"}, 32'(f3_bad), 32'd0);
    chk({tag, "_mem"}, 32'(mem_diffs()), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input logic [11:0] l,
                              input int ed, input int ew, input logic ee);
    vec_t v;
    v.src = s; v.dst = d; v.len = l; v.fill = 1'b0; v.fval = 32'h0;
    v.exp_done = ed; v.exp_writes = ew; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    int ndone, wr;
    bit hit;

    vecs.push_back(mk(32'h100,  32'h200, 12'd4, 6, 4, 1'b0));
    vecs.push_back(mk(32'h100,  32'h200, 12'd0, 1, 0, 1'b0));
    vecs.push_back(mk(32'h102,  32'h200, 12'd4, 1, 0, 1'b1));
    vecs.push_back(mk(32'h100,  32'h200, 12'd2, 4, 2, 1'b0));
    vecs.push_back(mk(32'h100,  32'h203, 12'd3, 1, 0, 1'b1));
    vecs.push_back(mk(32'h120,  32'h110, 12'd4, 6, 4, 1'b0));
    vecs.push_back(mk(32'h140,  32'h140, 12'd1, 3, 1, 1'b0));
    vecs.push_back(mk(32'h1FF8, 32'h180, 12'd4, 6, 4, 1'b0));
`ifdef FILL_EN
    v = mk(32'h0, 32'h300, 12'd3, 4, 3, 1'b0);
    v.fill = 1'b1; v.fval = 32'hDEADBEEF;
    vecs.push_back(v);
`endif

    rst_n = 1'b0; start = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; len_words = 12'd0;
`ifdef FILL_EN
    fill = 1'b0; fill_value = 32'h0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_read_addr", mem_read_address, 32'd0);
    chk("rst_write_addr", mem_write_address, 32'd0);
    chk("rst_funct3", {29'b0, mem_funct3}, 32'd2);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Second start while busy must be ignored.
    preload(16'h2200);
    v = mk(32'h100, 32'h200, 12'd4, 6, 4, 1'b0);
    ref_copy(v, 4);
    apply_start(v);
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (c == 2);
      if (c == 2) begin
        src_addr = 32'h300; dst_addr = 32'h600; len_words = 12'd2;
      end
    end
    chk("busy_start_done_pulses", 32'(ndone), 32'd1);
    chk("busy_start_busy_after", {31'b0, busy}, 32'd0);
    chk("busy_start_mem", 32'(mem_diffs()), 32'd0);

    // Reset asserted after two committed writes of an 8-word copy.
    preload(16'h3300);
    v = mk(32'h400, 32'h500, 12'd8, 10, 8, 1'b0);
    ref_copy(v, 2);
    apply_start(v);
    wr = 0; hit = 1'b0;
    for (int c = 1; c <= 20 && !hit; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (mem_write) wr++;
      if (wr == 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_mem_write", {31'b0, mem_write}, 32'd0);
        hit = 1'b1;
      end
    end
    chk("rst_mid_reached", {31'b0, hit}, 32'd1);
    @(negedge clk);
    chk("rst_mid_mem", 32'(mem_diffs()), 32'd0);
    rst_n = 1'b1;
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
